// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory read port and CPU issue handshake used by
//                fetch_unit. The master side is the fetch unit; the slave side
//                is the memory/CPU pair it feeds.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic [7:0]  mem_addr;     // instruction memory address
  logic        mem_rd;       // memory read strobe
  logic [15:0] mem_rdata;    // read data, valid one cycle after mem_rd
  logic [15:0] cpu_instr;    // registered instruction word
  logic        cpu_load;     // instruction-register load strobe
  logic        cpu_start;    // execute strobe
  logic        cpu_waiting;  // CPU ready for a new instruction

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    output cpu_instr,
    output cpu_load,
    output cpu_start,
    input  cpu_waiting
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    input  cpu_instr,
    input  cpu_load,
    input  cpu_start,
    output cpu_waiting
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Fetches 16-bit instruction words from an 8-bit addressed
//                memory and issues them one at a time to a CPU through a
//                load/start/waiting handshake. Supports free-running (run)
//                and single-step (step) operation.
//  Options     : FETCH_HALT_EN - when defined, a fetched word with opcode
//                bits[15:13] = 3'b111 parks the unit in HALT until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [7:0] START_PC = 8'h00
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_run,
  input  wire logic        i_step,
  fetch_unit_if.master     bus,
  output logic [7:0]       o_pc,
  output logic             o_busy,
  output logic             o_halted,
  output logic [15:0]      o_instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_LATCH     = 3'd2,
    S_LOAD      = 3'd3,
    S_START     = 3'd4,
    S_WAIT_BUSY = 3'd5,
    S_WAIT_DONE = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_count;

  logic        w_halt_word;
  logic        w_latch;
  logic        w_retire;
  logic        w_mem_rd;
  logic        w_cpu_load;
  logic        w_cpu_start;

`ifdef FETCH_HALT_EN
  // A halt opcode is recognised on the word arriving during LATCH.
  assign w_halt_word = (bus.mem_rdata[15:13] == 3'b111);
`else
  assign w_halt_word = 1'b0;
`endif

  // State register; reset wins on any edge it is low, even mid-instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_retire    = 1'b0;
    w_mem_rd    = 1'b0;
    w_cpu_load  = 1'b0;
    w_cpu_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        // run and step together behave exactly like run
        if (i_run || i_step) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        w_mem_rd = 1'b1;
        w_next   = S_LATCH;
      end
      S_LATCH: begin
        // A halt word is dropped here so it never reaches the CPU.
        if (w_halt_word) begin
          w_next = S_HALT;
        end else begin
          w_latch = 1'b1;
          w_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cpu_load = 1'b1;
        w_next     = S_START;
      end
      S_START: begin
        w_cpu_start = 1'b1;
        w_next      = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!bus.cpu_waiting) begin
          w_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // run is only consulted here, so dropping it mid-flight lets the
        // current instruction finish before returning to IDLE.
        if (bus.cpu_waiting) begin
          w_retire = 1'b1;
          w_next   = i_run ? S_READ : S_IDLE;
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Instruction register, program counter and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= START_PC;
      r_instr <= 16'h0000;
      r_count <= 16'h0000;
    end else begin
      if (w_latch) begin
        r_instr <= bus.mem_rdata;
      end
      if (w_retire) begin
        r_pc <= r_pc + 8'd1;
        if (r_count != c_COUNT_MAX) begin
          r_count <= r_count + 16'd1;
        end
      end
    end
  end

  assign bus.mem_addr  = r_pc;
  assign bus.mem_rd    = w_mem_rd;
  assign bus.cpu_instr = r_instr;
  assign bus.cpu_load  = w_cpu_load;
  assign bus.cpu_start = w_cpu_start;

  assign o_pc          = r_pc;
  assign o_instr_count = r_count;
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_HALT);

`ifdef FETCH_HALT_EN
  assign o_halted = (r_state == S_HALT);
`else
  assign o_halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Scoreboard bench for fetch_unit. Stimulus pushes expected
//                fetch addresses and issued instruction words; a monitor pops
//                and compares them whenever mem_rd or cpu_load is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        run2;
  logic        step2;
  logic [7:0]  pc,  pc2;
  logic        busy, busy2;
  logic        halted, halted2;
  logic [15:0] icount, icount2;

  logic [15:0] mem [256];
  int          cnt1, cnt2;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int start_cnt = 0;

  logic [7:0]  exp_addr  [$];
  logic [15:0] exp_instr [$];

  fetch_unit_if f ();
  fetch_unit_if f2 ();

  fetch_unit #(.START_PC(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_step(step), .bus(f),
    .o_pc(pc), .o_busy(busy), .o_halted(halted), .o_instr_count(icount)
  );

  fetch_unit #(.START_PC(8'hFF)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .i_run(run2), .i_step(step2), .bus(f2),
    .o_pc(pc2), .o_busy(busy2), .o_halted(halted2), .o_instr_count(icount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: data one cycle after mem_rd.
  always @(posedge clk) begin
    if (!rst_n) f.mem_rdata <= 16'h0000;
    else if (f.mem_rd) f.mem_rdata <= mem[f.mem_addr];
  end
  always @(posedge clk) begin
    if (!rst_n) f2.mem_rdata <= 16'h0000;
    else if (f2.mem_rd) f2.mem_rdata <= mem[f2.mem_addr];
  end

  // Stub CPUs: waiting drops the cycle after start, returns 4 cycles later.
  always @(posedge clk) begin
    if (!rst_n) begin
      f.cpu_waiting <= 1'b1; cnt1 <= 0;
    end else if (f.cpu_start) begin
      f.cpu_waiting <= 1'b0; cnt1 <= 4;
    end else if (cnt1 != 0) begin
      cnt1 <= cnt1 - 1;
      if (cnt1 == 1) f.cpu_waiting <= 1'b1;
    end
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      f2.cpu_waiting <= 1'b1; cnt2 <= 0;
    end else if (f2.cpu_start) begin
      f2.cpu_waiting <= 1'b0; cnt2 <= 4;
    end else if (cnt2 != 0) begin
      cnt2 <= cnt2 - 1;
      if (cnt2 == 1) f2.cpu_waiting <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got nothing expected event", name);
  endtask

  // Monitor: pops the scoreboard on every fetch and every issue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (f.mem_rd) begin
        rd_cnt++;
        if (exp_addr.size() == 0) fail_now("unexpected mem_rd");
        else check("mem_addr", f.mem_addr, exp_addr.pop_front());
      end
      if (f.cpu_load) begin
        if (exp_instr.size() == 0) fail_now("unexpected cpu_load");
        else check("cpu_instr", f.cpu_instr, exp_instr.pop_front());
      end
      if (f.cpu_start) start_cnt++;
      if ((f.mem_rd + f.cpu_load + f.cpu_start) > 1)
        check("strobe exclusivity", {29'd0, f.mem_rd, f.cpu_load, f.cpu_start}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; step = 1'b0; step2 = 1'b0;
    tick(); tick();
  endtask

  task automatic wait_idle(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    if (!done) fail_now("timeout waiting for idle");
  endtask

  task automatic wait_start(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      if (f.cpu_start) done = 1'b1;
      else tick();
    end
    if (!done) fail_now("timeout waiting for cpu_start");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    bit ok;
    run2 = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'hD105;
    mem[8'h01] = 16'h1234;
    mem[8'hFF] = 16'h0BCD;

    // Reset state
    do_reset();
    check("reset pc", pc, 8'h00);
    check("reset instr_count", icount, 16'h0000);
    check("reset cpu_instr", f.cpu_instr, 16'h0000);
    check("reset strobes", {f.mem_rd, f.cpu_load, f.cpu_start}, 3'b000);
    check("reset busy/halted", {busy, halted}, 2'b00);
    check("reset wrap pc", pc2, 8'hFF);

    // Single step with latency checks
    rst_n = 1'b1;
    step = 1'b1;
    exp_addr.push_back(8'h00);
    exp_instr.push_back(16'hD105);
    tick();
    step = 1'b0;
    check("step c1 mem_rd", f.mem_rd, 1'b1);
    check("step c1 busy", busy, 1'b1);
    tick();
    check("step c2 no load", f.cpu_load, 1'b0);
    tick();
    check("step c3 cpu_load", f.cpu_load, 1'b1);
    check("step c3 cpu_instr", f.cpu_instr, 16'hD105);
    tick();
    check("step c4 cpu_start", f.cpu_start, 1'b1);
    wait_idle(40);
    check("step pc", pc, 8'h01);
    check("step instr_count", icount, 16'd1);
    check("step cpu_instr holds", f.cpu_instr, 16'hD105);

    // Reset during WAIT_DONE
    step = 1'b1;
    exp_addr.push_back(8'h01);
    exp_instr.push_back(16'h1234);
    tick();
    step = 1'b0;
    wait_start(20);
    tick(); tick();
    check("midop in wait_done", {busy, f.cpu_waiting}, 2'b10);
    rst_n = 1'b0;
    tick();
    check("midop pc", pc, 8'h00);
    check("midop instr_count", icount, 16'd0);
    check("midop busy", busy, 1'b0);
    check("midop strobes", {f.mem_rd, f.cpu_load, f.cpu_start}, 3'b000);
    rst_n = 1'b1;

    // Run for three instructions
    mem[8'h00] = 16'h1111; mem[8'h01] = 16'h2222; mem[8'h02] = 16'h3333;
    mem[8'h03] = 16'h4444;
    for (int i = 0; i < 3; i++) exp_addr.push_back(i[7:0]);
    exp_instr.push_back(16'h1111);
    exp_instr.push_back(16'h2222);
    exp_instr.push_back(16'h3333);
    s0 = start_cnt;
    run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (start_cnt - s0 >= 3) ok = 1'b1;
    end
    if (!ok) fail_now("timeout run starts");
    run = 1'b0;
    wait_idle(40);
    check("run start pulses", start_cnt - s0, 3);
    check("run pc", pc, 8'h03);
    check("run instr_count", icount, 16'd3);

    // Run dropped during WAIT_DONE
    exp_addr.push_back(8'h03);
    exp_instr.push_back(16'h4444);
    s0 = start_cnt;
    r0 = rd_cnt;
    run = 1'b1;
    tick();
    wait_start(20);
    tick(); tick();
    run = 1'b0;
    wait_idle(40);
    repeat (5) tick();
    check("drop pc", pc, 8'h04);
    check("drop instr_count", icount, 16'd4);
    check("drop mem_rd count", rd_cnt - r0, 1);
    check("drop start count", start_cnt - s0, 1);

    // Wrap from START_PC = FF
    step2 = 1'b1;
    tick();
    step2 = 1'b0;
    check("wrap fetch rd", f2.mem_rd, 1'b1);
    check("wrap fetch addr", f2.mem_addr, 8'hFF);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (!busy2) ok = 1'b1;
    end
    if (!ok) fail_now("timeout wrap idle");
    check("wrap pc", pc2, 8'h00);
    check("wrap instr_count", icount2, 16'd1);

    // Halt opcode
    do_reset();
    rst_n = 1'b1;
    mem[8'h00] = 16'hE000;
    exp_addr.push_back(8'h00);
    s0 = start_cnt;
`ifdef FETCH_HALT_EN
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    check("halt halted", halted, 1'b1);
    check("halt busy", busy, 1'b0);
    check("halt pc", pc, 8'h00);
    check("halt instr_count", icount, 16'd0);
    repeat (5) tick();
    check("halt no start", start_cnt - s0, 0);
    check("halt sticky", halted, 1'b1);
    rst_n = 1'b0;
    tick();
    check("halt cleared by reset", halted, 1'b0);
    rst_n = 1'b1;
`else
    exp_instr.push_back(16'hE000);
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_idle(40);
    check("opcode7 start", start_cnt - s0, 1);
    check("opcode7 pc", pc, 8'h01);
    check("opcode7 halted", halted, 1'b0);
`endif

    tick();
    check("scoreboard addr drained", exp_addr.size(), 0);
    check("scoreboard instr drained", exp_instr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
